// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and counter-width helper for the serial subtractor
package serial_subtractor_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit gate-level subtract cell, d = a - b - bin with borrow out (ports a, b, bin -> d, bout)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output wire  d,
  output wire  bout
);
  wire t, na, nt, g, p;
  xor x1 (t, a, b);
  xor x2 (d, t, bin);
  not n1 (na, a);
  and a1 (g, na, b);
  not n2 (nt, t);
  and a2 (p, nt, bin);
  or  o1 (bout, g, p);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b over WIDTH cycles with start/busy/done framing (clk, rst, start, a, b -> busy, done, diff, borrow_out)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, sr_nx;
  logic [WIDTH-2:0] sr;
  logic [CW-1:0] count;
  logic br, d, bout, last;
  full_subtractor u_fs (.a(sa[0]), .b(sb[0]), .bin(br), .d(d), .bout(bout));
  assign last  = count == CW'(WIDTH - 1);
  assign sr_nx = {d, sr};
  assign busy  = state == ST_RUN;
  always_comb begin
    state_nx = state;
    state_nx = (state == ST_IDLE) ? (start ? ST_RUN : ST_IDLE) : (last ? ST_IDLE : ST_RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      br         <= 1'b0;
      count      <= '0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (state == ST_IDLE && start) begin
        sa    <= a;
        sb    <= b;
        br    <= 1'b0;
        count <= '0;
      end else if (state == ST_RUN) begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        sr    <= sr_nx[WIDTH-1:1];
        br    <= bout;
        count <= last ? '0 : count + 1'b1;
        if (last) begin
          diff       <= sr_nx;
          borrow_out <= bout;
          done       <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor against an arithmetic reference
module tb_serial_subtractor;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, borrow_out;
  logic [7:0] diff;
  int checks = 0, errors = 0;
  logic [8:0] q[$];
  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic op(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    a = x;
    b = y;
    q.push_back({x < y, 8'(x - y)});
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy !== 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'(n), 32'(0));
  endtask
  int run = 0;
  logic prev_done = 1'b0, prev_bo = 1'b0;
  logic [7:0] prev_diff = '0;
  always @(negedge clk) begin
    if (rst) run = 0;
    else begin
      if (busy === 1'b1) begin
        chk("hold", {diff, 7'd0, borrow_out}, {prev_diff, 7'd0, prev_bo});
        run++;
      end else begin
        if (done === 1'b1) chk("busy_len", 32'(run), 32'd8);
        run = 0;
      end
      if (done === 1'b1) begin
        chk("done_pulse", 32'(prev_done), 32'd0);
        if (q.size() == 0) chk("unexpected_done", {23'd0, borrow_out, diff}, 32'h1ff);
        else begin
          logic [8:0] e;
          e = q.pop_front();
          chk("result", {23'd0, borrow_out, diff}, {23'd0, e});
        end
      end
    end
    prev_done = done;
    prev_diff = diff;
    prev_bo   = borrow_out;
  end
  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_borrow", 32'(borrow_out), 0);
    op(8'h5A, 8'h3C); wait_idle();
    op(8'h10, 8'h20); wait_idle();
    op(8'h00, 8'h01); wait_idle();
    op(8'hFF, 8'hFF); wait_idle();
    op(8'h80, 8'h7F);
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    chk("no_extra_busy", 32'(busy), 0);
    op(8'h30, 8'h10);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", 32'(done), 1);
    chk("b2b_first_diff", 32'(diff), 32'h20);
    op(8'h05, 8'h07);
    chk("b2b_busy", 32'(busy), 1);
    wait_idle();
    chk("b2b_diff", 32'(diff), 32'hFE);
    chk("b2b_borrow", 32'(borrow_out), 1);
    op(8'h5A, 8'h3C);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_diff", 32'(diff), 0);
    chk("midrst_borrow", 32'(borrow_out), 0);
    repeat (15) @(negedge clk);
    chk("midrst_idle", 32'(busy), 0);
    op(8'h5A, 8'h3C); wait_idle();
    for (int i = 0; i < 30; i++) begin
      op(8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) wait_idle();
      else begin
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
          @(negedge clk);
          n++;
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
